// File: rtl/pixel_pair_serializer.sv
// pixel_pair_serializer: buffers 48-bit pixel pairs in a 2-deep FIFO and emits one 24-bit pixel per PIX_EN tick.
// Optional sticky underflow flag enabled by defining PIXEL_SERIALIZER_UNDERFLOW_EN.
module pixel_pair_serializer #(
    parameter int FRAME_WORDS = 38400,
    parameter int ADDR_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [47:0]       MEM_RGB,
    input  logic              WORD_VALID,
    output logic              WORD_READY,
    output logic [ADDR_W-1:0] ADDR,
    input  logic              FRAME_START,
    input  logic              PIX_EN,
    input  logic              ACTIVE,
    output logic [23:0]       RGB_OUT,
    output logic              RGB_VALID,
    output logic              UNDERFLOW
);
    logic [47:0]       head_q, head_d, tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              half_q, half_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              vld_q, vld_d;
    logic              push, disp, pop;

    assign WORD_READY = (count_q < 2'd2);
    assign ADDR       = addr_q;
    assign RGB_OUT    = rgb_q;
    assign RGB_VALID  = vld_q;

    // FIFO shift/fill, fetch address, and the pixel output stage; frame start flushes everything
    always_comb begin
        push    = WORD_VALID && WORD_READY;
        disp    = PIX_EN && ACTIVE && (count_q != 2'd0);
        pop     = disp && half_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop)
            head_d = (count_q == 2'd2) ? tail_q : MEM_RGB;
        else if (push && count_q == 2'd0)
            head_d = MEM_RGB;
        else if (push)
            tail_d = MEM_RGB;
        count_d = FRAME_START ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        half_d  = FRAME_START ? 1'b0 : half_q ^ disp;
        addr_d  = FRAME_START ? '0 :
                  !push ? addr_q :
                  (addr_q == ADDR_W'(FRAME_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
        rgb_d   = !PIX_EN ? rgb_q :
                  (disp && !FRAME_START) ? (half_q ? head_q[23:0] : head_q[47:24]) : 24'h000000;
        vld_d   = PIX_EN ? (disp && !FRAME_START) : vld_q;
    end

    // state register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            rgb_q   <= 24'h000000;
            vld_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            half_q  <= half_d;
            addr_q  <= addr_d;
            rgb_q   <= rgb_d;
            vld_q   <= vld_d;
        end
    end

`ifdef PIXEL_SERIALIZER_UNDERFLOW_EN
    logic und_q, und_d;

    // sticky flag set by a visible pixel request on an empty FIFO, cleared at frame start
    always_comb begin
        und_d = !FRAME_START && (und_q || (PIX_EN && ACTIVE && count_q == 2'd0));
    end

    // underflow flag register
    always_ff @(posedge CLK) begin
        if (RST)
            und_q <= 1'b0;
        else
            und_q <= und_d;
    end

    assign UNDERFLOW = und_q;
`else
    assign UNDERFLOW = 1'b0;
`endif
endmodule

// File: doc/pixel_pair_serializer.md
PIXEL_PAIR_SERIALIZER -- requirements
Module: pixel_pair_serializer

Interface
REQ-001 Parameter FRAME_WORDS, 38400, number of 16-bit memory words per frame (320x240 pixels, two pixels per word).
REQ-002 Parameter ADDR_W, 16, width of ADDR.
REQ-003 CLK  in  1  single system clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 MEM_RGB  in  48  decoded pixel pair: [47:24] first pixel, [23:0] second pixel, both 24-bit RGB.
REQ-006 WORD_VALID  in  1  MEM_RGB holds a valid pair this cycle.
REQ-007 WORD_READY  out  1  block accepts a pair this cycle.
REQ-008 ADDR  out  ADDR_W  memory word address of the next pair to fetch.
REQ-009 FRAME_START  in  1  single-cycle pulse at start of frame.
REQ-010 PIX_EN  in  1  pixel tick, one cycle per displayed pixel.
REQ-011 ACTIVE  in  1  current pixel lies in the visible area.
REQ-012 RGB_OUT  out  24  registered pixel colour to VGA DAC.
REQ-013 RGB_VALID  out  1  RGB_OUT carries fetched pixel data.
REQ-014 UNDERFLOW  out  1  sticky flag: pixel requested while buffer empty.

Function
REQ-015 Internal 2-entry FIFO of 48-bit pairs with 2-bit COUNT and a HALF select bit (0 = [47:24] next, 1 = [23:0] next).
REQ-016 WORD_READY SHALL equal (COUNT < 2) from registered state; no combinational path from WORD_VALID or PIX_EN.
REQ-017 Push occurs when WORD_VALID && WORD_READY; pushed pair stored in arrival order.
REQ-018 On push, ADDR SHALL increment by 1, wrapping from FRAME_WORDS-1 to 0.
REQ-019 On PIX_EN && ACTIVE with COUNT > 0: next cycle RGB_OUT = selected half of head entry, RGB_VALID = 1, HALF toggles.
REQ-020 Head entry SHALL be popped when it is output with HALF = 1.
REQ-021 On PIX_EN && ACTIVE with COUNT = 0: next cycle RGB_OUT = 24'h000000, RGB_VALID = 0, HALF unchanged, UNDERFLOW set.
REQ-022 On PIX_EN && !ACTIVE: next cycle RGB_OUT = 24'h000000, RGB_VALID = 0, FIFO and HALF unchanged.
REQ-023 Without PIX_EN, RGB_OUT and RGB_VALID SHALL hold their values.
REQ-024 Latency PIX_EN to RGB_OUT: exactly 1 cycle.
REQ-025 Simultaneous push and pop: COUNT unchanged; data ordering preserved; at COUNT = 2 no push occurs (REQ-016).
REQ-026 FRAME_START SHALL in the same edge clear COUNT, HALF, ADDR and UNDERFLOW, overriding any push or pop that cycle; RGB_OUT/RGB_VALID follow REQ-021/022 for that edge.

Reset
REQ-027 With RST high at an edge: COUNT = 0, HALF = 0, ADDR = 0, RGB_OUT = 24'h000000, RGB_VALID = 0, UNDERFLOW = 0; RST overrides all other inputs.
REQ-028 WORD_READY SHALL be 1 in the first cycle after RST deasserts.
REQ-029 RST asserted mid-pair SHALL discard the buffered pair and the pending second pixel.

Configuration
REQ-030 Macro PIXEL_SERIALIZER_UNDERFLOW_EN: when defined, UNDERFLOW behaves per REQ-014/021/026/027.
REQ-031 When PIXEL_SERIALIZER_UNDERFLOW_EN is undefined, UNDERFLOW port remains present and is tied to 0; all other behaviour identical.

Verification
REQ-032 Reset: RST high 2 cycles then low -> RGB_OUT 000000, RGB_VALID 0, ADDR 0, WORD_READY 1, UNDERFLOW 0.
REQ-033 Ordering: push MEM_RGB 48'heeff41039be5, then two PIX_EN with ACTIVE=1 -> RGB_OUT eeff41 then 039be5, RGB_VALID 1, ADDR 1, COUNT back to 0.
REQ-034 Full: push eeff41039be5 and 607d8b546e7a without PIX_EN -> WORD_READY 0, third WORD_VALID ignored, ADDR stays 2; two PIX_EN -> WORD_READY returns 1.
REQ-035 Underflow: PIX_EN with ACTIVE=1 on empty FIFO -> RGB_OUT 000000, RGB_VALID 0, UNDERFLOW 1 and held until FRAME_START (UNDERFLOW stays 0 when macro undefined).
REQ-036 Wrap: FRAME_WORDS=4, accept 5 pairs with PIX_EN draining -> ADDR sequence 1,2,3,0,1.
REQ-037 Mid-pair flush: push eeff41039be5, one PIX_EN (eeff41), FRAME_START, push 607d8b546e7a, PIX_EN -> RGB_OUT 607d8b (039be5 never output), ADDR 1.
